// File: rtl/avalon_mm_regbank_irq.sv
// Parametrised Avalon-MM register bank: RW control registers, RO status registers,
// sticky W1C event register with interrupt mask, constant ID word and level irq.
module avalon_mm_regbank_irq #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       N_RW     = 2,
    parameter int unsigned       N_RO     = 1,
    parameter int unsigned       ADDR_W   = 4,
    parameter logic [DATA_W-1:0] RW_RESET = '0,
    parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(32'h0001_0000)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     chipselect,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     write,
    input  logic [DATA_W-1:0]        writedata,
    input  logic [DATA_W/8-1:0]      byteenable,
    input  logic                     read,
    output logic [DATA_W-1:0]        readdata,
    output logic                     readdatavalid,
    output logic                     irq,
    output logic [N_RW*DATA_W-1:0]   rw_regs,
    output logic [N_RW-1:0]          rw_wr_pulse,
    input  logic [N_RO*DATA_W-1:0]   ro_data,
    input  logic [N_RO-1:0]          ro_we
);

    localparam int unsigned BE_W        = DATA_W / 8;
    localparam int unsigned STATUS_ADDR = N_RW + N_RO;
    localparam int unsigned MASK_ADDR   = STATUS_ADDR + 1;
    localparam int unsigned ID_ADDR     = STATUS_ADDR + 2;

    // Refuse to elaborate a map that cannot be addressed or stored.
    if (N_RW + N_RO + 3 > (1 << ADDR_W)) begin : g_map_check
        $error("avalon_mm_regbank_irq: address map does not fit in ADDR_W");
    end
    if ((DATA_W % 8) != 0 || N_RO > DATA_W) begin : g_width_check
        $error("avalon_mm_regbank_irq: DATA_W must be a multiple of 8 and >= N_RO");
    end

    logic                        wr_en;
    logic                        rd_en;
    logic [DATA_W-1:0]           lane_mask;
    logic [N_RO-1:0][DATA_W-1:0] ro_regs;
    logic [N_RO-1:0]             status;
    logic [DATA_W-1:0]           mask_reg;
    logic [DATA_W-1:0]           rd_mux;
    logic [N_RW-1:0]             wr_pulse_c;
    logic [N_RO-1:0]             status_clr;
    logic [N_RO-1:0]             status_next;
    logic                        sel_status;
    logic                        sel_mask;

    assign wr_en      = chipselect & write;
    assign rd_en      = chipselect & read;
    assign sel_status = (address == ADDR_W'(STATUS_ADDR));
    assign sel_mask   = (address == ADDR_W'(MASK_ADDR));

    // Expand byte enables to a bit mask.
    always_comb begin
        lane_mask = '0;
        for (int unsigned b = 0; b < BE_W; b++) begin
            lane_mask[b*8 +: 8] = {8{byteenable[b]}};
        end
    end

    // Address decode: read mux and RW write strobes.
    always_comb begin
        rd_mux     = '0;
        wr_pulse_c = '0;
        for (int unsigned i = 0; i < N_RW; i++) begin
            if (address == ADDR_W'(i)) begin
                rd_mux        = rw_regs[i*DATA_W +: DATA_W];
                wr_pulse_c[i] = wr_en;
            end
        end
        for (int unsigned i = 0; i < N_RO; i++) begin
            if (address == ADDR_W'(N_RW + i)) begin
                rd_mux = ro_regs[i];
            end
        end
        if (sel_status) begin
            rd_mux = DATA_W'(status);
        end
        if (sel_mask) begin
            rd_mux = mask_reg;
        end
        if (address == ADDR_W'(ID_ADDR)) begin
            rd_mux = ID_VALUE;
        end
    end

    // Sticky events: a load in the same cycle as a W1C keeps the bit set.
    always_comb begin
        status_clr = '0;
        if (wr_en && sel_status) begin
            status_clr = writedata[N_RO-1:0] & lane_mask[N_RO-1:0];
        end
        status_next = (status & ~status_clr) | ro_we;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rw_regs       <= {N_RW{RW_RESET}};
            ro_regs       <= '0;
            status        <= '0;
            mask_reg      <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            irq           <= 1'b0;
            rw_wr_pulse   <= '0;
        end else begin
            for (int unsigned i = 0; i < N_RW; i++) begin
                if (wr_pulse_c[i]) begin
                    rw_regs[i*DATA_W +: DATA_W] <= (rw_regs[i*DATA_W +: DATA_W] & ~lane_mask)
                                                 | (writedata & lane_mask);
                end
            end
            for (int unsigned i = 0; i < N_RO; i++) begin
                if (ro_we[i]) begin
                    ro_regs[i] <= ro_data[i*DATA_W +: DATA_W];
                end
            end
            if (wr_en && sel_mask) begin
                mask_reg <= (mask_reg & ~lane_mask) | (writedata & lane_mask);
            end
            status        <= status_next;
            readdatavalid <= rd_en;
            if (rd_en) begin
                readdata <= rd_mux;
            end
            irq         <= |(status & mask_reg[N_RO-1:0]);
            rw_wr_pulse <= wr_pulse_c;
        end
    end

endmodule

// File: tb/tb_avalon_mm_regbank_irq.sv
// Bench for avalon_mm_regbank_irq: directed vector table, random traffic against a
// behavioural register-map model, and an asynchronous reset in the middle of a read.
module tb_avalon_mm_regbank_irq;

    localparam logic [31:0] ID = 32'h0001_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic [3:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        irq;
    logic [63:0] rw_regs;
    logic [1:0]  rw_wr_pulse;
    logic [31:0] ro_data;
    logic [0:0]  ro_we;

    avalon_mm_regbank_irq dut (
        .clock(clock), .reset_n(reset_n), .chipselect(chipselect), .address(address),
        .write(write), .writedata(writedata), .byteenable(byteenable), .read(read),
        .readdata(readdata), .readdatavalid(readdatavalid), .irq(irq),
        .rw_regs(rw_regs), .rw_wr_pulse(rw_wr_pulse), .ro_data(ro_data), .ro_we(ro_we)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        cs;
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        rd;
        logic [31:0] rod;
        logic        rowe;
    } in_t;

    typedef struct {
        in_t         in;
        logic        ev;
        logic [31:0] ed;
        logic        ei;
        logic [1:0]  ep;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Register-map model: plain arrays holding what software would observe.
    logic [31:0] m_rw [2];
    logic [31:0] m_ro;
    logic [31:0] m_status;
    logic [31:0] m_mask;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_irq;
    logic [1:0]  e_pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic cs, input logic [3:0] addr, input logic wr,
                                input logic [31:0] wd, input logic [3:0] be, input logic rd,
                                input logic [31:0] rod, input logic rowe, input logic ev,
                                input logic [31:0] ed, input logic ei, input logic [1:0] ep);
        vec_t v;
        v.in.cs = cs; v.in.addr = addr; v.in.wr = wr; v.in.wd = wd; v.in.be = be;
        v.in.rd = rd; v.in.rod = rod; v.in.rowe = rowe;
        v.ev = ev; v.ed = ed; v.ei = ei; v.ep = ep;
        return v;
    endfunction

    task automatic model_reset();
        m_rw[0] = '0; m_rw[1] = '0; m_ro = '0; m_status = '0; m_mask = '0;
        e_valid = 1'b0; e_data = '0; e_irq = 1'b0; e_pulse = '0;
    endtask

    task automatic model_step(input in_t v);
        logic [31:0] bm;
        logic [31:0] old_val;
        int          a;
        a = int'(v.addr);
        case (a)
            0, 1:    old_val = m_rw[a];
            2:       old_val = m_ro;
            3:       old_val = m_status;
            4:       old_val = m_mask;
            5:       old_val = ID;
            default: old_val = '0;
        endcase
        e_valid = v.cs && v.rd;
        if (e_valid) e_data = old_val;
        e_irq   = (m_status & m_mask) != 0;
        e_pulse = '0;
        bm = '0;
        for (int b = 0; b < 4; b++) if (v.be[b]) bm = bm | (32'hFF << (8 * b));
        if (v.cs && v.wr) begin
            if (a < 2) begin
                m_rw[a] = (m_rw[a] & ~bm) | (v.wd & bm);
                e_pulse[a] = 1'b1;
            end else if (a == 3) begin
                m_status = m_status & ~(v.wd & bm & 32'h1);
            end else if (a == 4) begin
                m_mask = (m_mask & ~bm) | (v.wd & bm);
            end
        end
        if (v.rowe) begin
            m_ro = v.rod;
            m_status = 32'h1;
        end
    endtask

    task automatic apply(input in_t v);
        chipselect = v.cs; address = v.addr; write = v.wr; writedata = v.wd;
        byteenable = v.be; read = v.rd; ro_data = v.rod; ro_we = v.rowe;
    endtask

    // One bus cycle: drive at negedge, update the model, compare after the rising edge.
    task automatic drive_cycle(input in_t v, input string tag);
        apply(v);
        model_step(v);
        @(negedge clock);
        chk({tag, ".valid"}, 32'(readdatavalid), 32'(e_valid));
        if (e_valid) chk({tag, ".data"}, readdata, e_data);
        chk({tag, ".irq"}, 32'(irq), 32'(e_irq));
        chk({tag, ".pulse"}, 32'(rw_wr_pulse), 32'(e_pulse));
        chk({tag, ".rw0"}, rw_regs[31:0], m_rw[0]);
        chk({tag, ".rw1"}, rw_regs[63:32], m_rw[1]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];
        in_t  idle;
        in_t  r;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).in;
        // Defaults read back over the whole address space.
        for (int a = 0; a < 16; a++)
            tbl.push_back(mk(1, 4'(a), 0, 0, 0, 1, 0, 0, 1, (a == 5) ? ID : 32'h0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Byte-lane merge and RW write pulse.
        tbl.push_back(mk(1, 0, 1, 32'h11223344, 4'hF, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 1, 32'hDEADBEEF, 4'h5, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 32'h11AD33EF, 0, 2'b00));
        // RO load sets STATUS; irq two edges after ro_we.
        tbl.push_back(mk(1, 4, 1, 32'h1, 4'hF, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'hCAFE0001, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 1, 0, 0, 1, 32'hCAFE0001, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 1, 32'h1, 1, 0));
        // Set wins over W1C, then W1C alone clears and irq drops a cycle later.
        tbl.push_back(mk(1, 3, 1, 32'h1, 4'hF, 0, 32'hCAFE0002, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 1, 32'h1, 1, 0));
        tbl.push_back(mk(1, 3, 1, 32'h1, 4'hF, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 0));
        // Same-cycle read/write returns old value.
        tbl.push_back(mk(1, 1, 1, 32'h5, 4'hF, 1, 0, 0, 1, 32'h0, 0, 2'b10));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 32'h5, 0, 0));
        // RO read during its load returns the old value.
        tbl.push_back(mk(1, 2, 0, 0, 0, 1, 32'h12345678, 1, 1, 32'hCAFE0002, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 1, 0, 0, 1, 32'h12345678, 1, 0));
        // No chipselect: nothing happens.
        tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 32'h11AD33EF, 1, 0));
        // Writes to ID and RO ignored; W1C with no lanes enabled keeps the bit.
        tbl.push_back(mk(1, 5, 1, 32'h0, 4'hF, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 5, 0, 0, 0, 1, 0, 0, 1, ID, 1, 0));
        tbl.push_back(mk(1, 2, 1, 32'h0, 4'hF, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 1, 0, 0, 1, 32'h12345678, 1, 0));
        tbl.push_back(mk(1, 3, 1, 32'h1, 4'h0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0, 0, 1, 0, 0, 1, 32'h1, 1, 0));

        // Reset state.
        reset_n = 1'b0;
        apply(idle);
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset.valid", 32'(readdatavalid), 32'h0);
        chk("reset.data", readdata, 32'h0);
        chk("reset.irq", 32'(irq), 32'h0);
        chk("reset.rw", rw_regs[31:0] | rw_regs[63:32], 32'h0);
        chk("reset.pulse", 32'(rw_wr_pulse), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        foreach (tbl[k]) begin
            drive_cycle(tbl[k].in, $sformatf("vec%0d", k));
            chk($sformatf("vec%0d.tvalid", k), 32'(readdatavalid), 32'(tbl[k].ev));
            if (tbl[k].ev) chk($sformatf("vec%0d.tdata", k), readdata, tbl[k].ed);
            chk($sformatf("vec%0d.tirq", k), 32'(irq), 32'(tbl[k].ei));
            chk($sformatf("vec%0d.tpulse", k), 32'(rw_wr_pulse), 32'(tbl[k].ep));
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r.cs   = ($urandom_range(0, 3) != 0);
            r.addr = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 5));
            r.wr   = ($urandom_range(0, 1) != 0);
            r.rd   = ($urandom_range(0, 1) != 0);
            r.wd   = $urandom;
            r.be   = 4'($urandom);
            r.rod  = $urandom;
            r.rowe = ($urandom_range(0, 3) == 0);
            drive_cycle(r, $sformatf("rnd%0d", n));
        end

        // Bring irq high and fill RW0, then reset asynchronously mid-read.
        drive_cycle(mk(1, 4, 1, 32'h1, 4'hF, 0, 0, 0, 0, 0, 0, 0).in, "pre.mask");
        drive_cycle(mk(1, 0, 1, 32'hFFFFFFFF, 4'hF, 0, 32'h0BADF00D, 1, 0, 0, 0, 0).in, "pre.ro");
        drive_cycle(idle, "pre.idle1");
        drive_cycle(idle, "pre.idle2");
        apply(mk(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0).in);
        @(posedge clock);
        #2;
        chk("async.pre_valid", 32'(readdatavalid), 32'h1);
        chk("async.pre_irq", 32'(irq), 32'h1);
        chk("async.pre_rw0", rw_regs[31:0], 32'hFFFFFFFF);
        reset_n = 1'b0;
        #1;
        chk("async.valid", 32'(readdatavalid), 32'h0);
        chk("async.irq", 32'(irq), 32'h0);
        chk("async.data", readdata, 32'h0);
        chk("async.rw0", rw_regs[31:0], 32'h0);
        chk("async.rw1", rw_regs[63:32], 32'h0);
        apply(idle);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        drive_cycle(mk(1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0).in, "post.ro");
        drive_cycle(mk(1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0).in, "post.status");
        drive_cycle(mk(1, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0).in, "post.mask");
        drive_cycle(mk(1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0).in, "post.id");
        drive_cycle(idle, "post.idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
